// File: rtl/clk_div_multi.sv
// Multi-channel programmable divider: per-channel 50% square output, terminal-count tick, glitch-free divisor swap.
// Optional build macro CLKDIV_PHASE_EN adds WrPhase_i and a per-channel restart phase offset.
module clk_div_multi #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 26,
  parameter int DEF_DIV = 1250000,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic [NUM_CH-1:0] En_i,
  input  logic              SyncAll_i,
  input  logic              WrEn_i,
  input  logic [CH_W-1:0]   WrCh_i,
  input  logic [CNT_W-1:0]  WrDiv_i,
`ifdef CLKDIV_PHASE_EN
  input  logic [CNT_W-1:0]  WrPhase_i,
`endif
  output logic [NUM_CH-1:0] ClkOut_o,
  output logic [NUM_CH-1:0] Tick_o,
  output logic [NUM_CH-1:0] Pend_o
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [CNT_W-1:0]  div_q  [NUM_CH];
  logic [CNT_W-1:0]  div_d  [NUM_CH];
  logic [CNT_W-1:0]  pdiv_q [NUM_CH];
  logic [CNT_W-1:0]  pdiv_d [NUM_CH];
  logic [CNT_W-1:0]  base   [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] wr_hit, tc;

`ifdef CLKDIV_PHASE_EN
  logic [CNT_W-1:0]  phase_q [NUM_CH];
  logic [CNT_W-1:0]  phase_d [NUM_CH];
  logic [NUM_CH-1:0] en_q;

  function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction
`endif

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c] = WrEn_i && (WrCh_i == CH_W'(c));
      base[c]   = cnt_q[c];
`ifdef CLKDIV_PHASE_EN
      phase_d[c] = wr_hit[c] ? WrPhase_i : phase_q[c];
      if (En_i[c] && !en_q[c]) base[c] = min_cnt(phase_q[c], div_q[c]);
`endif
      // Compare with >= so a corrupted count can never run past the divisor
      tc[c]     = (base[c] >= div_q[c]);
      cnt_d[c]  = cnt_q[c];
      div_d[c]  = div_q[c];
      pdiv_d[c] = pdiv_q[c];
      pend_d[c] = pend_q[c];
      clk_d[c]  = clk_q[c];
      tick_d[c] = 1'b0;

      if (SyncAll_i || !En_i[c]) begin
        // Idle or resynchronising: the outputs are parked, so any divisor can be applied at once
        clk_d[c] = 1'b0;
        cnt_d[c] = '0;
        if (wr_hit[c]) begin
          div_d[c]  = WrDiv_i;
          pdiv_d[c] = WrDiv_i;
          pend_d[c] = 1'b0;
        end else if (pend_q[c]) begin
          div_d[c]  = pdiv_q[c];
          pend_d[c] = 1'b0;
        end
`ifdef CLKDIV_PHASE_EN
        if (SyncAll_i) cnt_d[c] = min_cnt(phase_d[c], div_d[c]);
`endif
      end else begin
        if (tc[c]) begin
          cnt_d[c]  = '0;
          clk_d[c]  = ~clk_q[c];
          tick_d[c] = 1'b1;
          // A write landing on the wrap cycle is queued rather than applied
          if (pend_q[c] && !wr_hit[c]) begin
            div_d[c]  = pdiv_q[c];
            pend_d[c] = 1'b0;
          end
        end else begin
          cnt_d[c] = base[c] + ONE;
        end
        if (wr_hit[c]) begin
          pdiv_d[c] = WrDiv_i;
          pend_d[c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]  <= '0;
        div_q[c]  <= DIV_RST;
        pdiv_q[c] <= DIV_RST;
      end
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

`ifdef CLKDIV_PHASE_EN
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      for (int c = 0; c < NUM_CH; c++) phase_q[c] <= '0;
      en_q <= '0;
    end else begin
      phase_q <= phase_d;
      en_q    <= En_i;
    end
  end
`endif

  assign ClkOut_o = clk_q;
  assign Tick_o   = tick_q;
  assign Pend_o   = pend_q;

endmodule
